// File: rtl/imsic_pkg.sv
// Shared field layout helpers for the IMSIC MSI record.
package imsic_pkg;

    localparam int unsigned SRC_LSB    = 0;
    localparam int unsigned M_FILE_IDX = 0;

    function automatic int unsigned file_lsb(input int unsigned nr_src_width);
        return nr_src_width;
    endfunction

    function automatic int unsigned hart_lsb(input int unsigned fifo_data_width,
                                             input int unsigned nr_harts_width);
        return fifo_data_width - nr_harts_width;
    endfunction

endpackage

// File: rtl/imsic_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with a one-cycle pulse on its rising edge.
module imsic_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync;
    logic                   sync_d;

    assign sync = chain[SYNC_STAGES-1];

    // rise is taken from a flop so the push lands SYNC_STAGES+1 edges after the first sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain  <= '0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], async_in};
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/imsic_msi_rx.sv
// Hart-side MSI receiver: synchronizes level-held records, filters them and queues setip requests.
module imsic_msi_rx
    import imsic_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = 17,
    parameter int unsigned NR_SRC_WIDTH    = 5,
    parameter int unsigned INTP_FILE_WIDTH = 3,
    parameter int unsigned NR_HARTS_WIDTH  = 6,
    parameter int unsigned NR_INTP_FILES   = 7,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NR_HARTS_WIDTH-1:0]  i_hart_id,
    input  logic [FIFO_DATA_WIDTH-1:0] i_msi_info,
    input  logic                       i_msi_info_vld,
    output logic                       o_setip_vld,
    output logic [INTP_FILE_WIDTH-1:0] o_setip_file,
    output logic [NR_SRC_WIDTH-1:0]    o_setip_num,
    input  logic                       i_setip_rdy,
    output logic                       o_drop,
    output logic [7:0]                 o_drop_cnt,
    input  logic                       i_cnt_clr
);

    localparam int unsigned AW         = $clog2(QUEUE_DEPTH);
    localparam int unsigned EW         = INTP_FILE_WIDTH + NR_SRC_WIDTH;
    localparam int unsigned FILE_LSB_P = file_lsb(NR_SRC_WIDTH);
    localparam int unsigned HART_LSB_P = hart_lsb(FIFO_DATA_WIDTH, NR_HARTS_WIDTH);

    logic                       rise;
    logic [NR_HARTS_WIDTH-1:0]  rec_hart;
    logic [INTP_FILE_WIDTH-1:0] rec_file;
    logic [NR_SRC_WIDTH-1:0]    rec_num;
    logic                       accepted;
    logic                       unused_info;

    logic [EW-1:0] q_mem [QUEUE_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    imsic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (i_msi_info_vld),
        .rise     (rise)
    );

    // the record is stable by the rise cycle, so fields are read straight off the port
    assign rec_hart    = i_msi_info[HART_LSB_P +: NR_HARTS_WIDTH];
    assign rec_file    = i_msi_info[FILE_LSB_P +: INTP_FILE_WIDTH];
    assign rec_num     = i_msi_info[SRC_LSB +: NR_SRC_WIDTH];
    assign unused_info = ^i_msi_info;

    assign accepted = (rec_hart == i_hart_id)
                    && (32'(rec_file) < NR_INTP_FILES)
                    && (rec_num != '0);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & i_setip_rdy;
    assign push  = rise & accepted & (~full | pop);
    assign drop  = rise & (~accepted | (full & ~pop));
    assign head  = q_mem[rd_ptr[AW-1:0]];

    assign o_setip_vld  = ~empty;
    assign o_setip_file = empty ? '0 : head[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
    assign o_setip_num  = empty ? '0 : head[0 +: NR_SRC_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_mem      <= '{default: '0};
            o_drop     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr[AW-1:0]] <= {rec_file, rec_num};
                wr_ptr                <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_drop <= drop;
            if (i_cnt_clr) begin
                o_drop_cnt <= '0;
            end else if (drop && (o_drop_cnt != '1)) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imsic_msi_rx.sv
// Randomized bench for imsic_msi_rx against a transaction-level queue/counter model.
module tb_imsic_msi_rx;

    localparam int QD      = 2;
    localparam int NF      = 7;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  hart_id = 6'd3;
    logic [16:0] info = '0;
    logic        vld = 1'b0;
    logic        setip_vld;
    logic [2:0]  setip_file;
    logic [4:0]  setip_num;
    logic        rdy = 1'b1;
    logic        drop;
    logic [7:0]  drop_cnt;
    logic        clr = 1'b0;

    int checks = 0;
    int errors = 0;

    imsic_msi_rx #(
        .FIFO_DATA_WIDTH (17),
        .NR_SRC_WIDTH    (5),
        .INTP_FILE_WIDTH (3),
        .NR_HARTS_WIDTH  (6),
        .NR_INTP_FILES   (NF),
        .SYNC_STAGES     (2),
        .QUEUE_DEPTH     (QD)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_hart_id      (hart_id),
        .i_msi_info     (info),
        .i_msi_info_vld (vld),
        .o_setip_vld    (setip_vld),
        .o_setip_file   (setip_file),
        .o_setip_num    (setip_num),
        .i_setip_rdy    (rdy),
        .o_drop         (drop),
        .o_drop_cnt     (drop_cnt),
        .i_cnt_clr      (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
        end
    endtask

    // reference model: each record is resolved LATENCY edges after its first sample
    typedef struct {
        int          edge_n;
        logic [16:0] rec;
    } ev_t;

    ev_t         pend[$];
    logic [7:0]  mq[$];
    int          mcnt = 0;
    bit          mdrop = 0;
    int          cyc = 0;

    function automatic logic [16:0] mk(input int h, input int f, input int n, input int junk);
        logic [5:0] hh;
        logic [2:0] ff;
        logic [2:0] jj;
        logic [4:0] nn;
        hh = h[5:0];
        ff = f[2:0];
        jj = junk[2:0];
        nn = n[4:0];
        return {hh, jj, ff, nn};
    endfunction

    always @(posedge clk) begin
        ev_t  e;
        bit   pop_m;
        bit   push_m;
        bit   drp;
        bit   acc;
        cyc++;
        if (rstn) begin
            pop_m  = (mq.size() > 0) && rdy;
            push_m = 0;
            drp    = 0;
            e      = '{0, '0};
            if (pend.size() > 0 && pend[0].edge_n == cyc) begin
                e   = pend.pop_front();
                acc = (e.rec[16:11] == hart_id) && (int'(e.rec[7:5]) < NF) && (e.rec[4:0] != 0);
                if (!acc)                          drp = 1;
                else if (mq.size() == QD && !pop_m) drp = 1;
                else                               push_m = 1;
            end
            if (pop_m)  void'(mq.pop_front());
            if (push_m) mq.push_back(e.rec[7:0]);
            mdrop = drp;
            if (clr)                   mcnt = 0;
            else if (drp && mcnt < 255) mcnt++;
        end
    end

    int  drop_pulses = 0;
    int  vld_cycles  = 0;
    int  vld_rise_cyc = -1;
    bit  vld_prev = 0;
    bit  chk_en = 0;

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            check("setip_vld", {31'b0, setip_vld}, {31'b0, mq.size() != 0});
            check("setip_file", {29'b0, setip_file}, (mq.size() != 0) ? {29'b0, mq[0][7:5]} : 32'd0);
            check("setip_num", {27'b0, setip_num}, (mq.size() != 0) ? {27'b0, mq[0][4:0]} : 32'd0);
            check("drop", {31'b0, drop}, {31'b0, mdrop});
            check("drop_cnt", {24'b0, drop_cnt}, mcnt);
            if (drop) drop_pulses++;
            if (setip_vld) vld_cycles++;
            if (setip_vld && !vld_prev) vld_rise_cyc = cyc;
            vld_prev = setip_vld;
        end
    end

    task automatic start_rec(input logic [16:0] r);
        ev_t e;
        info = r;
        vld  = 1'b1;
        e.edge_n = cyc + 1 + LATENCY;
        e.rec    = r;
        pend.push_back(e);
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rnd) rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [16:0] r, input int hold, input int gap, input bit rnd);
        start_rec(r);
        idle(hold, rnd);
        vld = 1'b0;
        idle(gap, rnd);
    endtask

    task automatic clear_cnt();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic model_reset();
        pend.delete();
        mq.delete();
        mcnt  = 0;
        mdrop = 0;
        vld_prev = 0;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_vld", {31'b0, setip_vld}, 32'd0);
        check("rst_file", {29'b0, setip_file}, 32'd0);
        check("rst_num", {27'b0, setip_num}, 32'd0);
        check("rst_drop", {31'b0, drop}, 32'd0);
        check("rst_cnt", {24'b0, drop_cnt}, 32'd0);
        #2 rstn = 1'b1;
        chk_en = 1;
        idle(2, 0);

        // single record and its latency
        rdy = 1'b1;
        vld_cycles = 0;
        k = cyc + 1;
        send(mk(3, 2, 17, 5), 4, 6, 0);
        check("single_vld_cycles", vld_cycles, 1);
        check("single_latency", vld_rise_cyc - k, LATENCY);
        check("single_cnt", {24'b0, drop_cnt}, 32'd0);

        // filtering: wrong hart, invalid file, zero identity
        drop_pulses = 0;
        vld_cycles  = 0;
        send(mk(4, 1, 5, 0), 4, 3, 0);
        send(mk(3, 7, 5, 0), 4, 3, 0);
        send(mk(3, 1, 0, 7), 4, 3, 0);
        idle(2, 0);
        check("filt_pulses", drop_pulses, 3);
        check("filt_cnt", {24'b0, drop_cnt}, 32'd3);
        check("filt_vld_cycles", vld_cycles, 0);
        clear_cnt();

        // backpressure overflow
        rdy = 1'b0;
        send(mk(3, 1, 1, 0), 4, 3, 0);
        send(mk(3, 1, 2, 0), 4, 3, 0);
        send(mk(3, 1, 3, 0), 4, 3, 0);
        idle(2, 0);
        check("bp_cnt", {24'b0, drop_cnt}, 32'd1);
        check("bp_head", {27'b0, setip_num}, 32'd1);
        rdy = 1'b1;
        idle(4, 0);
        clear_cnt();

        // push and pop in the same cycle while full
        rdy = 1'b0;
        send(mk(3, 3, 7, 0), 4, 3, 0);
        send(mk(3, 4, 8, 0), 4, 3, 0);
        start_rec(mk(3, 5, 9, 0));
        idle(3, 0);
        rdy = 1'b1;
        idle(1, 0);
        vld = 1'b0;
        idle(5, 0);
        check("pp_cnt", {24'b0, drop_cnt}, 32'd0);

        // long level, slow source
        vld_cycles = 0;
        send(mk(3, 0, 12, 0), 16, 8, 0);
        send(mk(3, 6, 13, 0), 16, 8, 0);
        check("long_vld_cycles", vld_cycles, 2);

        // saturation and clear-priority
        for (int i = 0; i < 256; i++) send(mk(3, 1, 0, 0), 4, 3, 0);
        check("sat_cnt", {24'b0, drop_cnt}, 32'd255);
        start_rec(mk(5, 1, 1, 0));
        idle(3, 0);
        clr = 1'b1;
        idle(1, 0);
        clr = 1'b0;
        vld = 1'b0;
        check("clr_cnt", {24'b0, drop_cnt}, 32'd0);
        idle(3, 0);

        // reset mid-synchronization with the level still high at release
        start_rec(mk(3, 2, 21, 0));
        @(negedge clk);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check("rstmid_vld", {31'b0, setip_vld}, 32'd0);
        check("rstmid_cnt", {24'b0, drop_cnt}, 32'd0);
        idle(3, 0);
        #2 rstn = 1'b1;
        begin
            ev_t e;
            e.edge_n = cyc + 1 + LATENCY;
            e.rec    = info;
            pend.push_back(e);
        end
        vld_cycles = 0;
        idle(4, 0);
        vld = 1'b0;
        idle(4, 0);
        check("rstmid_new_rec", vld_cycles, 1);
        send(mk(3, 1, 22, 0), 4, 4, 0);

        // randomized records with random backpressure
        for (int i = 0; i < 60; i++) begin
            int h;
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 3;
            send(mk(h, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 7))),
                 int'($urandom_range(4, 9)), int'($urandom_range(3, 6)), 1);
        end
        rdy = 1'b1;
        idle(6, 0);
        check("final_empty", {31'b0, setip_vld}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
